// File: rtl/holy_axi_ram.sv
// AXI4 slave RAM for cache refill/write-back traffic: INCR and FIXED bursts of
// 32-bit beats, one transaction at a time, writes take priority over reads.
module holy_axi_ram #(
  parameter int          MEM_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  // write address
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        awvalid,
  output logic        awready,
  // write data
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  // write response
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  // read address
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic        arvalid,
  output logic        arready,
  // read data
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, W_DATA, W_RESP, R_DATA} state_t;

  // A request is rejected on bad size, WRAP/reserved burst, an address below
  // the base (borrow out of diff), or a burst that would run off the array.
  function automatic logic req_err(input logic [32:0] diff, input logic [7:0] len,
                                   input logic [2:0] size, input logic [1:0] burst);
    logic [32:0] off;
    off = diff >> 2;
    return (size != 3'b010) || burst[1] || diff[32] ||
           ((burst == BURST_INCR) ? ((off + 33'(len)) >= 33'(MEM_WORDS))
                                  : (off >= 33'(MEM_WORDS)));
  endfunction

  logic [31:0]      mem [MEM_WORDS];

  state_t           state;
  logic [3:0]       id_q;
  logic [IDX_W-1:0] ptr;
  logic [7:0]       len_q;
  logic [7:0]       cnt;
  logic [1:0]       burst_q;
  logic             err;

  logic             aw_rdy_q;
  logic             w_rdy_q;
  logic             b_vld_q;
  logic             r_vld_q;
  logic             r_last_q;

  logic [32:0]      aw_diff;
  logic [32:0]      ar_diff;
  logic [IDX_W-1:0] aw_word;
  logic [IDX_W-1:0] ar_word;
  logic             aw_err;
  logic             ar_err;
  logic [IDX_W-1:0] ptr_step;
  logic             last_beat;
  logic             aw_hs;
  logic             ar_hs;
  logic             w_hs;
  logic             b_hs;
  logic             r_hs;

  // Handshake outputs are forced low while rst is high so nothing is
  // transferred in the reset cycle itself.
  assign awready = aw_rdy_q & ~rst;
  assign arready = aw_rdy_q & ~awvalid & ~rst;
  assign wready  = w_rdy_q & ~rst;
  assign bvalid  = b_vld_q & ~rst;
  assign rvalid  = r_vld_q & ~rst;
  assign rlast   = r_last_q & ~rst;

  assign aw_hs = awvalid & awready;
  assign ar_hs = arvalid & arready;
  assign w_hs  = wvalid & wready;
  assign b_hs  = bvalid & bready;
  assign r_hs  = rvalid & rready;

  assign aw_diff = {1'b0, awaddr} - {1'b0, BASE_ADDR};
  assign ar_diff = {1'b0, araddr} - {1'b0, BASE_ADDR};
  assign aw_word = aw_diff[IDX_W+1:2];
  assign ar_word = ar_diff[IDX_W+1:2];
  assign aw_err  = req_err(aw_diff, awlen, awsize, awburst);
  assign ar_err  = req_err(ar_diff, arlen, arsize, arburst);

  assign ptr_step  = (burst_q == BURST_INCR) ? ptr + IDX_W'(1) : ptr;
  assign last_beat = (cnt == len_q);

  // NOTE: the array has no reset so it maps onto block RAM; only the control
  // registers around it are reset.
  always_ff @(posedge clk) begin
    if (w_hs && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[ptr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours (ptr/cnt/rdata depend on it).
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      aw_rdy_q <= 1'b1;
      w_rdy_q  <= 1'b0;
      b_vld_q  <= 1'b0;
      r_vld_q  <= 1'b0;
      r_last_q <= 1'b0;
      id_q     <= '0;
      ptr      <= '0;
      len_q    <= '0;
      cnt      <= '0;
      burst_q  <= '0;
      err      <= 1'b0;
      bid      <= '0;
      bresp    <= RESP_OKAY;
      rid      <= '0;
      rresp    <= RESP_OKAY;
      rdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (aw_hs) begin
            id_q     <= awid;
            ptr      <= aw_word;
            len_q    <= awlen;
            cnt      <= '0;
            burst_q  <= awburst;
            err      <= aw_err;
            aw_rdy_q <= 1'b0;
            w_rdy_q  <= 1'b1;
            state    <= W_DATA;
          end else if (ar_hs) begin
            id_q     <= arid;
            ptr      <= ar_word;
            len_q    <= arlen;
            cnt      <= '0;
            burst_q  <= arburst;
            err      <= ar_err;
            aw_rdy_q <= 1'b0;
            r_vld_q  <= 1'b1;
            r_last_q <= (arlen == 8'd0);
            rid      <= arid;
            rresp    <= ar_err ? RESP_SLVERR : RESP_OKAY;
            rdata    <= ar_err ? '0 : mem[ar_word];
            state    <= R_DATA;
          end
        end

        W_DATA: begin
          if (w_hs) begin
            ptr <= ptr_step;
            cnt <= cnt + 8'd1;
            // A misplaced wlast only flags the burst; its length is set by len.
            if (wlast != last_beat) err <= 1'b1;
            if (last_beat) begin
              w_rdy_q <= 1'b0;
              b_vld_q <= 1'b1;
              bid     <= id_q;
              bresp   <= (err || (wlast != last_beat)) ? RESP_SLVERR : RESP_OKAY;
              state   <= W_RESP;
            end
          end
        end

        W_RESP: begin
          if (b_hs) begin
            b_vld_q  <= 1'b0;
            bid      <= '0;
            bresp    <= RESP_OKAY;
            aw_rdy_q <= 1'b1;
            state    <= IDLE;
          end
        end

        R_DATA: begin
          if (r_hs) begin
            if (last_beat) begin
              r_vld_q  <= 1'b0;
              r_last_q <= 1'b0;
              rid      <= '0;
              rresp    <= RESP_OKAY;
              rdata    <= '0;
              aw_rdy_q <= 1'b1;
              state    <= IDLE;
            end else begin
              ptr      <= ptr_step;
              cnt      <= cnt + 8'd1;
              r_last_q <= ((cnt + 8'd1) == len_q);
              rdata    <= err ? '0 : mem[ptr_step];
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
